// File: rtl/flash_read_checker.sv
// Checks the 256-byte SPI flash read burst against a BASE + k*STEP pattern and
// reports pass/fail, byte and error counts, the first mismatch and LED status.
module flash_read_checker #(
    parameter int         NUM_BYTES    = 256,
    parameter int         CNT_W        = 9,
    parameter logic [7:0] PATTERN_BASE = 8'h00,
    parameter logic [7:0] PATTERN_STEP = 8'h01,
    parameter int         TIMEOUT_CYC  = 50000
) (
    input  logic             clock25M,
    input  logic             reset,
    input  logic             chk_start,
    input  logic             flash_done,
    input  logic [7:0]       mydata_o,
    input  logic             myvalid_o,
    output logic             chk_busy,
    output logic             chk_done,
    output logic             chk_pass,
    output logic             chk_timeout,
    output logic [CNT_W-1:0] byte_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] first_err_idx,
    output logic [7:0]       first_err_data,
    output logic [3:0]       led
);
    typedef enum logic [1:0] {IDLE, ARMED, RUN, FINISH} state_t;

    localparam logic [CNT_W-1:0] NB     = CNT_W'(NUM_BYTES);
    localparam logic [CNT_W-1:0] ONES   = '1;
    localparam logic [15:0]      TO_CYC = 16'(TIMEOUT_CYC);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d, err_cnt_q, err_cnt_d;
    logic [CNT_W-1:0] first_err_idx_q, first_err_idx_d;
    logic [7:0]       first_err_data_q, first_err_data_d, exp_q, exp_d;
    logic [15:0]      idle_q, idle_d;
    logic             timeout_q, timeout_d, pass_q, pass_d;
    logic             active;

    always_comb begin
        state_d          = state_q;
        byte_cnt_d       = byte_cnt_q;
        err_cnt_d        = err_cnt_q;
        first_err_idx_d  = first_err_idx_q;
        first_err_data_d = first_err_data_q;
        exp_d            = exp_q;
        idle_d           = idle_q;
        timeout_d        = timeout_q;
        pass_d           = pass_q;
        active           = (state_q == ARMED) || (state_q == RUN);

        if (chk_start) begin
            state_d          = ARMED;
            byte_cnt_d       = '0;
            err_cnt_d        = '0;
            first_err_idx_d  = ONES;
            first_err_data_d = 8'h00;
            exp_d            = PATTERN_BASE;
            idle_d           = '0;
            timeout_d        = 1'b0;
            pass_d           = 1'b0;
        end else if (active) begin
            idle_d = idle_q + 16'd1;
            if (myvalid_o) begin
                idle_d = '0;
                if (state_q == ARMED) state_d = RUN;
                // Overrun bytes are counted but never compared; the count alone fails the burst.
                if (byte_cnt_q < NB) begin
                    if (mydata_o != exp_q) begin
                        if (err_cnt_q != ONES) err_cnt_d = err_cnt_q + 1'b1;
                        if (err_cnt_q == '0) begin
                            first_err_idx_d  = byte_cnt_q;
                            first_err_data_d = mydata_o;
                        end
                    end
                    exp_d = exp_q + PATTERN_STEP;
                end
                if (byte_cnt_q != ONES) byte_cnt_d = byte_cnt_q + 1'b1;
            end
            if (flash_done) begin
                state_d = FINISH;
            end else if (idle_d >= TO_CYC) begin
                timeout_d = 1'b1;
                state_d   = FINISH;
            end
            // Verdict uses this cycle's updates so a byte landing with flash_done still counts.
            if (state_d == FINISH)
                pass_d = (byte_cnt_d == NB) && (err_cnt_d == '0) && !timeout_d;
        end
    end

    always_ff @(posedge clock25M or posedge reset) begin
        if (reset) begin
            state_q          <= IDLE;
            byte_cnt_q       <= '0;
            err_cnt_q        <= '0;
            first_err_idx_q  <= ONES;
            first_err_data_q <= 8'h00;
            exp_q            <= PATTERN_BASE;
            idle_q           <= '0;
            timeout_q        <= 1'b0;
            pass_q           <= 1'b0;
        end else begin
            state_q          <= state_d;
            byte_cnt_q       <= byte_cnt_d;
            err_cnt_q        <= err_cnt_d;
            first_err_idx_q  <= first_err_idx_d;
            first_err_data_q <= first_err_data_d;
            exp_q            <= exp_d;
            idle_q           <= idle_d;
            timeout_q        <= timeout_d;
            pass_q           <= pass_d;
        end
    end

    assign chk_busy       = (state_q == ARMED) || (state_q == RUN);
    assign chk_done       = (state_q == FINISH);
    assign chk_pass       = pass_q;
    assign chk_timeout    = timeout_q;
    assign byte_cnt       = byte_cnt_q;
    assign err_cnt        = err_cnt_q;
    assign first_err_idx  = first_err_idx_q;
    assign first_err_data = first_err_data_q;
    assign led            = {timeout_q, chk_done & ~pass_q, pass_q, chk_busy};
endmodule

// File: tb/tb_flash_read_checker.sv
// Directed bench for flash_read_checker: clean, corrupted, short/long, timeout,
// coincident last byte/done, and mid-burst reset bursts.
module tb_flash_read_checker;
    localparam int TO = 300;

    logic       clock25M = 1'b0;
    logic       reset = 1'b1;
    logic       chk_start = 1'b0, flash_done = 1'b0, myvalid_o = 1'b0;
    logic [7:0] mydata_o = 8'h00;
    logic       chk_busy, chk_done, chk_pass, chk_timeout;
    logic [8:0] byte_cnt, err_cnt, first_err_idx;
    logic [7:0] first_err_data;
    logic [3:0] led;

    int checks = 0, errors = 0;
    int inj_idx0 = -1, inj_idx1 = -1;
    logic [7:0] inj_val0 = 8'h00, inj_val1 = 8'h00;

    flash_read_checker #(.TIMEOUT_CYC(TO)) dut (
        .clock25M(clock25M), .reset(reset), .chk_start(chk_start), .flash_done(flash_done),
        .mydata_o(mydata_o), .myvalid_o(myvalid_o), .chk_busy(chk_busy), .chk_done(chk_done),
        .chk_pass(chk_pass), .chk_timeout(chk_timeout), .byte_cnt(byte_cnt), .err_cnt(err_cnt),
        .first_err_idx(first_err_idx), .first_err_data(first_err_data), .led(led)
    );

    always #5 clock25M = ~clock25M;

    task automatic tick();
        @(posedge clock25M);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start();
        chk_start = 1'b1;
        tick();
        chk_start = 1'b0;
    endtask

    task automatic send(input logic [7:0] d);
        mydata_o  = d;
        myvalid_o = 1'b1;
        tick();
        myvalid_o = 1'b0;
    endtask

    // Sends bytes 0..n-1 of the pattern (k mod 256), with up to two injected corruptions.
    task automatic burst(input int n);
        for (int k = 0; k < n; k++) begin
            if (k == inj_idx0)      send(inj_val0);
            else if (k == inj_idx1) send(inj_val1);
            else                    send(8'(k));
        end
    endtask

    task automatic done_pulse();
        flash_done = 1'b1;
        tick();
        flash_done = 1'b0;
    endtask

    initial begin
        repeat (3) tick();
        check("rst_busy", chk_busy, 0);
        check("rst_done", chk_done, 0);
        check("rst_bytecnt", byte_cnt, 0);
        check("rst_first_idx", first_err_idx, 9'h1FF);
        check("rst_first_data", first_err_data, 0);
        check("rst_led", led, 4'b0000);
        reset = 1'b0;
        tick();

        // 1: clean burst
        start();
        check("t1_armed_led", led, 4'b0001);
        burst(256);
        check("t1_pre_done", chk_done, 0);
        done_pulse();
        check("t1_done", chk_done, 1);
        check("t1_pass", chk_pass, 1);
        check("t1_bytecnt", byte_cnt, 256);
        check("t1_errcnt", err_cnt, 0);
        check("t1_first_idx", first_err_idx, 9'h1FF);
        check("t1_led", led, 4'b0010);
        // FINISH ignores further traffic
        send(8'h55);
        done_pulse();
        check("t1_ignore_bytecnt", byte_cnt, 256);
        check("t1_ignore_pass", chk_pass, 1);

        // 2: two corrupted bytes
        inj_idx0 = 17;  inj_val0 = 8'hAA;
        inj_idx1 = 200; inj_val1 = 8'h00;
        start();
        check("t2_restart_clear", byte_cnt, 0);
        burst(256);
        done_pulse();
        inj_idx0 = -1; inj_idx1 = -1;
        check("t2_errcnt", err_cnt, 2);
        check("t2_first_idx", first_err_idx, 17);
        check("t2_first_data", first_err_data, 8'hAA);
        check("t2_pass", chk_pass, 0);
        check("t2_led", led, 4'b0100);

        // 3: short and long bursts
        start();
        burst(255);
        done_pulse();
        check("t3_short_bytecnt", byte_cnt, 255);
        check("t3_short_pass", chk_pass, 0);
        check("t3_short_led", led, 4'b0100);
        start();
        burst(257);
        done_pulse();
        check("t3_long_bytecnt", byte_cnt, 257);
        check("t3_long_errcnt", err_cnt, 0);
        check("t3_long_pass", chk_pass, 0);

        // 4: timeout with no bytes
        start();
        repeat (TO - 1) tick();
        check("t4_pre_busy", chk_busy, 1);
        check("t4_pre_done", chk_done, 0);
        tick();
        check("t4_done", chk_done, 1);
        check("t4_timeout", chk_timeout, 1);
        check("t4_led", led, 4'b1100);

        // 5: last byte coincident with flash_done
        start();
        burst(255);
        mydata_o = 8'hFF; myvalid_o = 1'b1; flash_done = 1'b1;
        tick();
        myvalid_o = 1'b0; flash_done = 1'b0;
        check("t5_bytecnt", byte_cnt, 256);
        check("t5_pass", chk_pass, 1);
        check("t5_done", chk_done, 1);

        // 6: reset mid-burst, then a clean burst
        start();
        burst(100);
        #2 reset = 1'b1;
        #1;
        check("t6_rst_busy", chk_busy, 0);
        check("t6_rst_bytecnt", byte_cnt, 0);
        check("t6_rst_first_idx", first_err_idx, 9'h1FF);
        check("t6_rst_led", led, 4'b0000);
        #2 reset = 1'b0;
        tick();
        start();
        burst(256);
        done_pulse();
        check("t6_pass", chk_pass, 1);
        check("t6_bytecnt", byte_cnt, 256);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
